// File: rtl/vga_timing_recovery.sv
// vga_timing_recovery: rebuild VGA raster counters from h/v sync edges, check timing, lock
//   clock       : pixel clock, all state on posedge
//   reset       : asynchronous active-low reset
//   h_sync      : horizontal sync, active low
//   v_sync      : vertical sync, active low
//   h_count     : recovered column
//   v_count     : recovered row
//   active      : visible pixel while locked
//   frame_start : pulse at (0,0) while locked
//   locked      : raster timing verified
//   timing_err  : pulse on bad line, bad frame or sync timeout
module vga_timing_recovery #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC_LOAD = 658,
  parameter int V_TOTAL     = 521,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC_LOAD = 490,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       active,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err
);
  typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;
  localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HL  = 10'(H_SYNC_LOAD);
  localparam logic [9:0] VT  = 10'(V_TOTAL);
  localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VL  = 10'(V_SYNC_LOAD);
  localparam logic [2:0] LF  = 3'(LOCK_FRAMES);
  state_t     state, state_n;
  logic       hs_prev, vs_prev, frame_armed, armed_n, err_n;
  logic [9:0] line_len, line_cnt;
  logic [2:0] good_frames, good_n;
  logic       hfe, vfe, h_wrap, good_line, good_frame, timeout, bad;
  assign hfe        = ~h_sync & hs_prev;
  assign vfe        = ~v_sync & vs_prev;
  assign h_wrap     = ~hfe && h_count == HT1;
  assign good_line  = line_len == HT1;
  assign good_frame = line_cnt == VT;
  assign timeout    = line_len == 10'h3ff;
  assign bad        = (hfe && !good_line) || timeout || (vfe && frame_armed && !good_frame);
  assign locked      = state == LOCKED;
  assign active      = locked && h_count < HA && v_count < VA;
  assign frame_start = locked && h_count == 10'd0 && v_count == 10'd0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      h_count     <= '0;
      v_count     <= '0;
      line_len    <= '0;
      line_cnt    <= '0;
      state       <= SEARCH;
      good_frames <= '0;
      frame_armed <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      hs_prev     <= h_sync;
      vs_prev     <= v_sync;
      h_count     <= hfe ? HL : h_wrap ? 10'd0 : h_count + 10'd1;
      v_count     <= vfe ? VL : h_wrap ? (v_count == VT1 ? 10'd0 : v_count + 10'd1) : v_count;
      line_len    <= hfe ? 10'd0 : timeout ? line_len : line_len + 10'd1;
      // an hfe coinciding with vfe is the first line of the new frame
      line_cnt    <= vfe ? {9'd0, hfe} : (hfe && line_cnt != 10'h3ff) ? line_cnt + 10'd1 : line_cnt;
      state       <= state_n;
      good_frames <= good_n;
      frame_armed <= armed_n;
      timing_err  <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    good_n  = good_frames;
    armed_n = frame_armed;
    err_n   = 1'b0;
    if (state == SEARCH) begin
      if (hfe && good_line) begin
        state_n = HLOCK;
        good_n  = '0;
        armed_n = 1'b0;
      end
    end else if (bad) begin
      state_n = SEARCH;
      good_n  = '0;
      armed_n = 1'b0;
      err_n   = 1'b1;
    end else if (vfe) begin
      // the first frame after line lock is partial and only arms judging
      if (!frame_armed) armed_n = 1'b1;
      else if (state == HLOCK) begin
        good_n = good_frames + 3'd1;
        if (good_n == LF) state_n = LOCKED;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_recovery.sv
module tb_vga_timing_recovery;
  localparam int HT = 50, HA = 40, HS0 = 42, HS1 = 47, HL = 44;
  localparam int VT = 14, VA = 10, VS0 = 11, VS1 = 13, VL = 11, LF = 2;
  localparam int FR = HT * VT;
  logic clk = 0, rst_n = 0, hs = 1, vs = 1;
  logic [9:0] h_count, v_count;
  logic active, frame_start, locked, timing_err;
  always #5 clk = ~clk;
  vga_timing_recovery #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_LOAD(HL),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_LOAD(VL), .LOCK_FRAMES(LF)
  ) dut (
    .clock(clk), .reset(rst_n), .h_sync(hs), .v_sync(vs),
    .h_count(h_count), .v_count(v_count), .active(active),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err)
  );
  typedef struct packed {logic [9:0] h, v; logic act, fs, lk, te;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int col = 0, line = 0, hlen = HT, vlen = VT;
  bit force_h = 0, noise = 0, in_rst = 1;
  int mh, mv, since_h, lines, ms, good;
  bit armed, phs, pvs;
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  function automatic void model_reset();
    mh = 0; mv = 0; since_h = 1; lines = 0; ms = 0; good = 0;
    armed = 0; phs = 1; pvs = 1;
  endfunction
  // Reference: raster position as modular arithmetic from the last sync edges,
  // lock judged from measured line length and lines per frame.
  function automatic void model_apply(bit s_h, bit s_v);
    bit hfe, vfe, wrap, gl, gf, to, bad, te;
    exp_t e;
    hfe = !s_h && phs;
    vfe = !s_v && pvs;
    wrap = !hfe && mh == HT - 1;
    gl = since_h == HT;
    gf = lines == VT;
    to = since_h >= 1024;
    mh = hfe ? HL : (mh + 1) % HT;
    if (vfe) mv = VL;
    else if (wrap) mv = (mv + 1) % VT;
    since_h = hfe ? 1 : (since_h < 2000 ? since_h + 1 : since_h);
    if (vfe) lines = hfe ? 1 : 0;
    else if (hfe) lines++;
    te = 0;
    bad = (hfe && !gl) || to || (vfe && armed && !gf);
    if (ms == 0) begin
      if (hfe && gl) begin ms = 1; good = 0; armed = 0; end
    end else if (bad) begin
      ms = 0; good = 0; armed = 0; te = 1;
    end else if (vfe) begin
      if (!armed) armed = 1;
      else if (ms == 1) begin good++; if (good == LF) ms = 2; end
    end
    phs = s_h;
    pvs = s_v;
    e.h = 10'(mh);
    e.v = 10'(mv);
    e.lk = ms == 2;
    e.act = e.lk && mh < HA && mv < VA;
    e.fs = e.lk && mh == 0 && mv == 0;
    e.te = te;
    q.push_back(e);
  endfunction
  function automatic void drive();
    hs = force_h | (noise ? ($urandom_range(0, 15) != 0) : !(col >= HS0 && col < HS1));
    vs = noise ? ($urandom_range(0, 63) != 0) : !(line >= VS0 && line < VS1);
  endfunction
  function automatic void advance();
    col++;
    if (col >= hlen) begin
      col = 0; hlen = HT; line++;
      if (line >= vlen) begin line = 0; vlen = VT; end
    end
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    if (!in_rst) model_apply(hs, vs);
    advance();
    drive();
  endtask
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {h_count, v_count, active, frame_start, locked, timing_err};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL cycle @%0t: got h=%0d v=%0d act=%b fs=%b lk=%b te=%b expected h=%0d v=%0d act=%b fs=%b lk=%b te=%b",
                   $time, got.h, got.v, got.act, got.fs, got.lk, got.te, e.h, e.v, e.act, e.fs, e.lk, e.te);
        end
      end
    end
  end
  task automatic do_reset();
    #2 rst_n = 0;
    in_rst = 1;
    q.delete();
    #1;
    check("rst_h_count", h_count, 0);
    check("rst_v_count", v_count, 0);
    check("rst_active", active, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_locked", locked, 0);
    check("rst_timing_err", timing_err, 0);
    repeat (3) step();
    #1 rst_n = 1;
    model_reset();
    in_rst = 0;
  endtask
  task automatic wait_lock(string name, int bound);
    int n = 0;
    while (!locked && n < bound) begin step(); n++; end
    check(name, locked, 1);
  endtask
  task automatic wait_err(string name, int bound);
    int n = 0;
    while (!timing_err && n < bound) begin step(); n++; end
    check(name, timing_err, 1);
    check({name, "_unlocked"}, locked, 0);
  endtask
  task automatic frame_stats(string name);
    int a = 0, f = 0;
    repeat (FR) begin step(); a += active; f += frame_start; end
    check({name, "_active"}, a, HA * VA);
    check({name, "_frame_start"}, f, 1);
  endtask
  initial begin
    int n, te_cnt;
    col = $urandom_range(0, HT - 1);
    line = $urandom_range(0, VT - 1);
    drive();
    model_reset();
    step();
    do_reset();
    wait_lock("lock_init", 3 * FR + 2 * HT);
    frame_stats("locked_frame");
    repeat ($urandom_range(1, FR)) step();
    do_reset();
    wait_lock("relock_after_reset", 3 * FR + 2 * HT);
    n = 0;
    while (col > 4 && n < HT) begin step(); n++; end
    hlen = HT - 1;
    wait_err("bad_line", 2 * HT);
    wait_lock("relock_bad_line", 3 * FR + 2 * HT);
    n = 0;
    while (line != 0 && n < FR) begin step(); n++; end
    vlen = VT - 1;
    wait_err("bad_frame", 2 * FR);
    wait_lock("relock_bad_frame", 3 * FR + 2 * HT);
    force_h = 1;
    te_cnt = 0;
    repeat (1100) begin step(); te_cnt += timing_err; end
    check("sync_loss_err_pulses", te_cnt, 1);
    check("sync_loss_unlocked", locked, 0);
    force_h = 0;
    wait_lock("relock_sync_loss", 3 * FR + 3 * HT);
    noise = 1;
    repeat (2 * FR) step();
    noise = 0;
    wait_lock("relock_after_noise", 3 * FR + 3 * HT);
    frame_stats("final_frame");
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
